// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue
// Purpose  : Write-side companion of the register file. Buffers ALU results
//            in a small in-order FIFO and drives the single register-file
//            write port, oldest entry first. Writes to register 0 are
//            accepted but dropped, since that register is hardwired to zero.
//            A per-register "pending" vector lets hazard logic see which
//            registers still have a write in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   single clock, all state updates on rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   producer offers a result
//   in_ready   out  queue can accept a result (registered state + rst_n only)
//   in_rd      in   destination register index
//   in_data    in   result value
//   RegWrite   out  register-file write enable (queue not empty)
//   WriteAddr  out  register-file write index (head entry, 0 when empty)
//   WriteData  out  register-file write data  (head entry, 0 when empty)
//   wr_stall   in   register-file write port busy this cycle
//   pending    out  bit r set = a write to register r is still queued
//   count      out  number of queued entries
// ============================================================================
module writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_rd,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      RegWrite,
   output logic [ADDR_W-1:0]         WriteAddr,
   output logic [DATA_W-1:0]         WriteData,
   input  logic                      wr_stall,
   output logic [(2**ADDR_W)-1:0]    pending,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_NREG  = 2**ADDR_W;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

   // -------------------------------------------------------------------------
   // Queue state
   // -------------------------------------------------------------------------
   logic [ADDR_W-1:0]  addr_q [DEPTH];
   logic [DATA_W-1:0]  data_q [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [c_PTR_W-1:0] head_q,  head_d;
   logic [c_PTR_W-1:0] tail_q,  tail_d;
   logic [c_CNT_W-1:0] count_q, count_d;

   logic w_full;
   logic w_accept;
   logic w_enq;
   logic w_deq;
   logic w_nonempty;

   assign w_full     = (count_q == c_DEPTH);
   assign w_nonempty = (count_q != '0);

   // Readiness depends only on registered occupancy and reset, so a full
   // queue refuses a result even on a cycle where it is also draining.
   assign in_ready = rst_n & ~w_full;
   assign w_accept = in_valid & in_ready;

   // Register 0 is never written: complete the handshake but store nothing.
   assign w_enq = w_accept & (in_rd != '0);

   // wr_stall is meaningless while empty; the nonempty term masks it.
   assign w_deq = w_nonempty & ~wr_stall;

   // -------------------------------------------------------------------------
   // Next-state logic for pointers, occupancy and entry valid bits
   // -------------------------------------------------------------------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;

      if (w_deq) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;   // power-of-two depth wraps naturally
      end

      // Enqueue can only happen when not full, so tail never equals a live
      // head slot here and the clear above cannot be overridden wrongly.
      if (w_enq) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end

      case ({w_enq, w_deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload storage needs no reset: slots are only observed while valid.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         addr_q[tail_q] <= in_rd;
         data_q[tail_q] <= in_data;
      end
   end

   // -------------------------------------------------------------------------
   // Register-file write port: head entry, forced to zero when empty
   // -------------------------------------------------------------------------
   assign RegWrite  = w_nonempty;
   assign WriteAddr = w_nonempty ? addr_q[head_q] : '0;
   assign WriteData = w_nonempty ? data_q[head_q] : '0;
   assign count     = count_q;

   // -------------------------------------------------------------------------
   // Pending vector: OR of per-entry index matches over live entries only.
   // Duplicate writes to one register keep the bit set until the last one
   // leaves, because every live match contributes.
   // -------------------------------------------------------------------------
   generate
      for (genvar r = 0; r < c_NREG; r++) begin : g_pend
         if (r == 0) begin : g_zero
            assign pending[r] = 1'b0;
         end else begin : g_reg
            logic [DEPTH-1:0] w_hit;
            for (genvar e = 0; e < DEPTH; e++) begin : g_ent
               assign w_hit[e] = valid_q[e] & (addr_q[e] == ADDR_W'(r));
            end
            assign pending[r] = |w_hit;
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameters SHALL be, one per line:
  DEPTH, 4, number of buffered write entries (power of two, >=2)
  DATA_W, 32, register data width
  ADDR_W, 5, register index width (32 registers)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state updates on rising edge
  rst_n  input  1  synchronous, active-low reset
  in_valid  input  1  producer offers a result
  in_ready  output  1  queue can accept a result
  in_rd  input  ADDR_W  destination register index
  in_data  input  DATA_W  result value
  RegWrite  output  1  register-file write enable
  WriteAddr  output  ADDR_W  register-file write index
  WriteData  output  DATA_W  register-file write data
  wr_stall  input  1  register-file write port busy this cycle
  pending  output  2**ADDR_W  bit r set = write to register r still queued
  count  output  log2(DEPTH)+1  number of queued entries
REQ-003 Reset SHALL be one clock, synchronous and active-low (rst_n sampled on rising edge of clk).

Function
REQ-004 Block SHALL be the write-side counterpart of the register file: buffers ALU results and drives the register-file write port in strict arrival order.
REQ-005 Accept SHALL occur on an edge where in_valid=1 and in_ready=1.
REQ-006 in_ready SHALL equal (count<DEPTH) and rst_n=1; no combinational path from wr_stall or in_valid to in_ready.
REQ-007 Accepted entry with in_rd=0 SHALL be discarded: handshake completes, nothing enqueued, count and pending unchanged.
REQ-008 Accepted entry with in_rd!=0 SHALL be written at tail, tail pointer incremented modulo DEPTH.
REQ-009 RegWrite SHALL equal (count!=0); WriteAddr/WriteData SHALL present the head entry; when count=0 WriteAddr and WriteData SHALL be 0.
REQ-010 Dequeue SHALL occur on an edge where RegWrite=1 and wr_stall=0; head pointer incremented modulo DEPTH.
REQ-011 Latency: entry accepted on edge N into empty queue SHALL appear on the write port in the cycle after edge N; no same-cycle bypass.
REQ-012 Simultaneous accept (rd!=0) and dequeue SHALL leave count unchanged; accept alone +1; dequeue alone -1.
REQ-013 Full (count=DEPTH): in_ready=0 even if a dequeue occurs that cycle; accept resumes the following cycle.
REQ-014 Empty: wr_stall SHALL be ignored; no dequeue, count stays 0.
REQ-015 wr_stall=1 SHALL hold head entry and RegWrite=1 stable until the edge where wr_stall=0.
REQ-016 pending[r] SHALL be 1 iff at least one queued entry has index r; pending[0] SHALL always be 0; multiple queued writes to the same r SHALL keep pending[r]=1 until the last is dequeued.
REQ-017 pending SHALL be derived from registered queue state only (no dependence on in_valid).
REQ-018 Pointer wrap-around SHALL be seamless; order preserved across wrap.

Reset
REQ-019 On an edge with rst_n=0: count=0, head=tail=0, all entries invalid; resulting outputs RegWrite=0, WriteAddr=0, WriteData=0, pending=0.
REQ-020 While rst_n=0, in_ready SHALL be 0 and no accept SHALL occur; in_ready=1 in the first cycle with rst_n=1.
REQ-021 Reset mid-operation SHALL drop all queued entries; no register-file write issues after the reset edge.

Verification
REQ-022 Single write: accept rd=3, data=0xDEADBEEF on edge N -> RegWrite=1, WriteAddr=3, WriteData=0xDEADBEEF after edge N; count=0 after edge N+1.
REQ-023 Fill/stall: wr_stall=1, accept rd=1..4 -> count=4, in_ready=0, pending=0x1E; release stall -> writes 1,2,3,4 on four consecutive edges, pending=0.
REQ-024 Zero register: accept rd=0, data=5 -> in_ready handshake completes, count stays 0, RegWrite stays 0.
REQ-025 Duplicate/wrap: stream 10 entries rd=7,7,8,... with wr_stall toggling -> output order equals input order; pending[7]=1 until second rd=7 write dequeues.
REQ-026 Full with dequeue: count=4, wr_stall=0, in_valid=1 -> no accept that edge, count=3, accept next edge, count stays 3 with continued draining.
REQ-027 Reset mid-stream: count=3, assert rst_n=0 one edge -> count=0, RegWrite=0, pending=0, in_ready=1 the cycle after rst_n returns high.
